// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : datapath width, ALU function codes and group codes             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int WIDTH = 32;

  typedef logic [5:0] alu_func_t;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam alu_func_t ALUFUNC_ADD   = 6'b000000;
  localparam alu_func_t ALUFUNC_SUB   = 6'b000001;
  localparam alu_func_t ALUFUNC_AND   = 6'b011000;
  localparam alu_func_t ALUFUNC_OR    = 6'b011110;
  localparam alu_func_t ALUFUNC_XOR   = 6'b010110;
  localparam alu_func_t ALUFUNC_NOR   = 6'b010001;
  localparam alu_func_t ALUFUNC_PASSA = 6'b011010;
  localparam alu_func_t ALUFUNC_SLL   = 6'b100000;
  localparam alu_func_t ALUFUNC_SRL   = 6'b100001;
  localparam alu_func_t ALUFUNC_SRA   = 6'b100011;
  localparam alu_func_t ALUFUNC_EQ    = 6'b110011;
  localparam alu_func_t ALUFUNC_NEQ   = 6'b110001;
  localparam alu_func_t ALUFUNC_LT    = 6'b110101;
  localparam alu_func_t ALUFUNC_LEZ   = 6'b111101;
  localparam alu_func_t ALUFUNC_GEZ   = 6'b111001;
  localparam alu_func_t ALUFUNC_GTZ   = 6'b111111;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// +--------------------------------------------------------------------------+
// | alu_if : operand/function bus into the ALU and registered result out     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Signed;
  alu_func_t        ALUFunc;
  logic [WIDTH-1:0] S;

  modport master (output A, output B, output Signed, output ALUFunc, input S);
  modport slave  (input A, input B, input Signed, input ALUFunc, output S);

endinterface

`default_nettype wire

// File: rtl/alu_arith.sv
// +--------------------------------------------------------------------------+
// | alu_arith : adder/subtractor with Zero, Overflow and Negative flags      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arith
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             neg_o
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;
  logic             w_carry;
  logic             w_sovf;
  logic             w_uovf;

  assign w_b     = sub_i ? ~b_i : b_i;
  assign w_full  = {1'b0, a_i} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub_i};
  assign sum_o   = w_full[WIDTH-1:0];
  assign w_carry = w_full[WIDTH];

  // For subtraction the borrow is the inverted carry out of A + ~B + 1.
  assign w_sovf  = (a_i[WIDTH-1] == w_b[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  assign w_uovf  = w_carry ^ sub_i;

  assign zero_o  = (sum_o == '0);
  assign ovf_o   = signed_i ? w_sovf : w_uovf;
  assign neg_o   = signed_i ? (sum_o[WIDTH-1] ^ w_sovf) : (sub_i & ~w_carry);

endmodule

`default_nettype wire

// File: rtl/alu.sv
// +--------------------------------------------------------------------------+
// | alu : 32-bit MIPS ALU (arith, logic, shift, compare), registered result  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [WIDTH-1:0] w_sum;
  logic             w_zero;
  logic             w_neg;
  logic             w_ovf_unused;
  logic             w_sub;
  logic [1:0]       w_grp;
  logic [3:0]       w_lut;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_shift;
  logic             w_cmp;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;

  assign w_grp   = bus.ALUFunc[5:4];
  assign w_lut   = bus.ALUFunc[3:0];
  assign w_shamt = bus.A[4:0];
  // Compares always need A-B for EQ/NEQ/LT.
  assign w_sub   = (w_grp == GRP_CMP) | bus.ALUFunc[0];

  alu_arith u_arith (
    .a_i      (bus.A),
    .b_i      (bus.B),
    .sub_i    (w_sub),
    .signed_i (bus.Signed),
    .sum_o    (w_sum),
    .zero_o   (w_zero),
    .ovf_o    (w_ovf_unused),
    .neg_o    (w_neg)
  );

  always_comb begin
    w_logic = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_logic[i] = w_lut[{bus.B[i], bus.A[i]}];
    end
  end

  always_comb begin
    w_shift = bus.B << w_shamt;
    case (bus.ALUFunc[1:0])
      2'b01:   w_shift = bus.B >> w_shamt;
      2'b11:   w_shift = $signed(bus.B) >>> w_shamt;
      default: w_shift = bus.B << w_shamt;
    endcase
  end

  // Zero-relative compares treat A as signed regardless of the Signed input.
  always_comb begin
    w_cmp = 1'b0;
    case (bus.ALUFunc[3:1])
      3'b001:  w_cmp = w_zero;
      3'b000:  w_cmp = ~w_zero;
      3'b010:  w_cmp = w_neg;
      3'b110:  w_cmp = bus.A[WIDTH-1] | (bus.A == '0);
      3'b100:  w_cmp = ~bus.A[WIDTH-1];
      3'b111:  w_cmp = ~bus.A[WIDTH-1] & (bus.A != '0);
      default: w_cmp = 1'b0;
    endcase
  end

  always_comb begin
    s_d = w_sum;
    case (w_grp)
      GRP_ARITH: s_d = w_sum;
      GRP_LOGIC: s_d = w_logic;
      GRP_SHIFT: s_d = w_shift;
      GRP_CMP:   s_d = {{(WIDTH-1){1'b0}}, w_cmp};
      default:   s_d = w_sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign bus.S = s_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// +--------------------------------------------------------------------------+
// | tb_alu : scoreboard bench for alu, directed cases plus random traffic    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    total;
  int    bad;
  exp_t  exp_q[$];

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model computed straight from the operation definitions.
  function automatic logic [31:0] model(alu_func_t f, logic [31:0] a, logic [31:0] b, logic sg);
    logic [31:0] r;
    int          sh;
    r  = '0;
    sh = int'(a[4:0]);
    case (f[5:4])
      2'b00: r = f[0] ? (a - b) : (a + b);
      2'b01: begin
        for (int i = 0; i < 32; i++) begin
          if (b[i] && a[i])       r[i] = f[3];
          else if (b[i] && !a[i]) r[i] = f[2];
          else if (!b[i] && a[i]) r[i] = f[1];
          else                    r[i] = f[0];
        end
      end
      2'b10: begin
        if (f[1:0] == 2'b01)      r = b >> sh;
        else if (f[1:0] == 2'b11) r = b[31] ? ~((~b) >> sh) : (b >> sh);
        else                      r = b << sh;
      end
      default: begin
        case (f[3:1])
          3'b001: r = {31'b0, a == b};
          3'b000: r = {31'b0, a != b};
          3'b010: r = sg ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
          3'b110: r = {31'b0, $signed(a) <= 32'sd0};
          3'b100: r = {31'b0, $signed(a) >= 32'sd0};
          3'b111: r = {31'b0, $signed(a) > 32'sd0};
          default: r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic issue(alu_func_t f, logic [31:0] a, logic [31:0] b, logic sg,
                       logic [31:0] exp, string tag);
    exp_t e;
    @(negedge clk);
    bus.ALUFunc = f;
    bus.A       = a;
    bus.B       = b;
    bus.Signed  = sg;
    e.exp = exp;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_now(logic [31:0] exp, string tag);
    total++;
    if (bus.S !== exp) begin
      bad++;
      $display("FAIL %s: S=%h expected %h", tag, bus.S, exp);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one result per clock edge, popped one edge after issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.S !== e.exp) begin
          bad++;
          $display("FAIL %s: S=%h expected %h", e.tag, bus.S, e.exp);
        end
      end
    end
  end

  initial begin
    alu_func_t codes[16];
    alu_func_t f;
    logic [31:0] a;
    logic [31:0] b;
    logic sg;

    codes = '{ALUFUNC_ADD, ALUFUNC_SUB, ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR,
              ALUFUNC_NOR, ALUFUNC_PASSA, ALUFUNC_SLL, ALUFUNC_SRL, ALUFUNC_SRA,
              ALUFUNC_EQ, ALUFUNC_NEQ, ALUFUNC_LT, ALUFUNC_LEZ, ALUFUNC_GEZ, ALUFUNC_GTZ};
    total = 0;
    bad   = 0;
    bus.A = '0; bus.B = '0; bus.Signed = 1'b0; bus.ALUFunc = ALUFUNC_OR;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_now(32'h0, "reset_initial");
    repeat (2) @(posedge clk);
    #1 check_now(32'h0, "reset_held");
    #1 rst_n = 1'b1;

    issue(ALUFUNC_AND,   32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000D, "and");
    issue(ALUFUNC_OR,    32'd15, 32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFDF, "or");
    issue(ALUFUNC_XOR,   32'd15, 32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFD2, "xor");
    issue(ALUFUNC_NOR,   32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_0020, "nor");
    issue(ALUFUNC_PASSA, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'h0000_000F, "pass_a");
    issue(ALUFUNC_SLL,   32'd22, 32'hFFFF_FFDD, 1'b0, 32'hF740_0000, "sll22");
    issue(ALUFUNC_SRL,   32'd3,  32'hFFFF_FFDD, 1'b0, 32'h1FFF_FFFB, "srl3");
    issue(ALUFUNC_SRA,   32'd3,  32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFFB, "sra3");
    issue(ALUFUNC_SLL,   32'd0,  32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFDD, "sll0");
    issue(ALUFUNC_SRA,   32'd31, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, "sra31");
    issue(ALUFUNC_SRL,   32'd31, 32'h8000_0000, 1'b0, 32'h0000_0001, "srl31");
    issue(6'b100010,     32'd4,  32'h0000_0003, 1'b0, 32'h0000_0030, "shift10_sll");
    issue(ALUFUNC_SUB,   32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFE, "sub");
    issue(ALUFUNC_ADD,   32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, "add_wrap");
    issue(ALUFUNC_EQ,    32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, "eq");
    issue(ALUFUNC_NEQ,   32'hFFFF_FFFF, 32'd1, 1'b0, 32'h1, "neq");
    issue(ALUFUNC_LT,    32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, "lt_unsigned");
    issue(ALUFUNC_LT,    32'hFFFF_FFFF, 32'd1, 1'b1, 32'h1, "lt_signed");
    issue(ALUFUNC_EQ,    32'h1234_5678, 32'h1234_5678, 1'b0, 32'h1, "eq_true");
    issue(ALUFUNC_LEZ,   32'hFFFF_FFFF, 32'd0, 1'b1, 32'h1, "lez_neg");
    issue(ALUFUNC_GEZ,   32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0, "gez_neg");
    issue(ALUFUNC_GTZ,   32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0, "gtz_neg");
    issue(ALUFUNC_LEZ,   32'hFFFF_FFFF, 32'd0, 1'b0, 32'h1, "lez_neg_unsigned");
    issue(ALUFUNC_LEZ,   32'd0, 32'd0, 1'b1, 32'h1, "lez_zero");
    issue(ALUFUNC_GEZ,   32'd0, 32'd0, 1'b1, 32'h1, "gez_zero");
    issue(ALUFUNC_GTZ,   32'd0, 32'd0, 1'b1, 32'h0, "gtz_zero");
    issue(ALUFUNC_GTZ,   32'd5, 32'd0, 1'b1, 32'h1, "gtz_pos");
    issue(ALUFUNC_LT,    32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'h0, "lt_bound_signed");
    issue(ALUFUNC_LT,    32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h1, "lt_bound_unsigned");
    issue(ALUFUNC_ADD,   32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, "add_ovf_wrap");
    issue(6'b000010,     32'd7, 32'd9, 1'b0, 32'd16, "func000010_add");
    issue(6'b110111,     32'd3, 32'd3, 1'b0, 32'h0, "cmp_code011");
    wait_drain();

    // Async reset in the middle of a cycle, then reload on the next edge.
    issue(ALUFUNC_OR, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFDF, "pre_reset");
    wait_drain();
    #1 rst_n = 1'b0;
    #1 check_now(32'h0, "async_reset");
    @(posedge clk);
    #1 check_now(32'h0, "reset_hold_edge");
    rst_n = 1'b1;
    issue(ALUFUNC_OR, 32'd15, 32'hFFFF_FFDD, 1'b0, 32'hFFFF_FFDF, "post_reset_load");
    wait_drain();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) f = codes[$urandom_range(0, 15)];
      else                           f = alu_func_t'($urandom_range(0, 63));
      a  = pick();
      b  = pick();
      sg = 1'($urandom_range(0, 1));
      issue(f, a, b, sg, model(f, a, b, sg), $sformatf("rand f=%b a=%h b=%h sg=%0d", f, a, b, sg));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
